// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Sweep FSM encoding, golden table default and vector count.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] GOLDEN_DEFAULT = 16'h7310;
    localparam int unsigned VEC_COUNT      = 16;
    localparam logic [3:0]  VEC_LAST       = 4'(VEC_COUNT - 1);
    localparam logic [4:0]  FAIL_CNT_MAX   = 5'(VEC_COUNT);

    function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
        return (cnt == FAIL_CNT_MAX) ? cnt : cnt + 5'd1;
    endfunction

endpackage

// File: rtl/tt_cmp.sv
// Combinational comparator: every implementation output vs the golden bit.
// Yields a per-implementation mismatch vector and an any-mismatch flag.
module tt_cmp
    import tt_sweep_pkg::*;
#(
    parameter int N_IMPL = 6
) (
    input  logic [N_IMPL-1:0] i_resp,
    input  logic              i_exp,
    output logic [N_IMPL-1:0] o_mismatch,
    output logic              o_any
);

    assign o_mismatch = i_resp ^ {N_IMPL{i_exp}};
    assign o_any      = |o_mismatch;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive 4-input truth-table sweep against N_IMPL implementations.
// Optional TT_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter logic [15:0] GOLDEN = GOLDEN_DEFAULT,
    parameter int          N_IMPL = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [3:0]        vec,
    input  logic [N_IMPL-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IMPL-1:0] err_mask,
    output logic [4:0]        fail_cnt,
    output logic [3:0]        first_fail
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_vec;
    logic [3:0]        w_vec_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_pass;
    logic              w_pass_nxt;
    logic [N_IMPL-1:0] r_err_mask;
    logic [N_IMPL-1:0] w_err_mask_nxt;
    logic [4:0]        r_fail_cnt;
    logic [4:0]        w_fail_cnt_nxt;
    logic [3:0]        r_first_fail;
    logic [3:0]        w_first_fail_nxt;

    logic              w_exp;
    logic [N_IMPL-1:0] w_mismatch;
    logic              w_any;
    logic              w_end;

    assign w_exp = GOLDEN[r_vec];

    tt_cmp #(
        .N_IMPL     (N_IMPL)
    ) u_cmp (
        .i_resp     (resp),
        .i_exp      (w_exp),
        .o_mismatch (w_mismatch),
        .o_any      (w_any)
    );

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    assign w_end = w_any || (r_vec == VEC_LAST);
`else
    assign w_end = (r_vec == VEC_LAST);
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_vec_nxt        = r_vec;
        w_done_nxt       = 1'b0;
        w_pass_nxt       = r_pass;
        w_err_mask_nxt   = r_err_mask;
        w_fail_cnt_nxt   = r_fail_cnt;
        w_first_fail_nxt = r_first_fail;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt      = DRIVE;
                    w_vec_nxt        = 4'd0;
                    w_pass_nxt       = 1'b0;
                    w_err_mask_nxt   = '0;
                    w_fail_cnt_nxt   = 5'd0;
                    w_first_fail_nxt = 4'd0;
                end
            end
            DRIVE: begin
                w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                w_err_mask_nxt = r_err_mask | w_mismatch;
                if (w_any) begin
                    w_fail_cnt_nxt = sat_inc(r_fail_cnt);
                    if (r_fail_cnt == 5'd0) begin
                        w_first_fail_nxt = r_vec;
                    end
                end
                // vec stays put on the last (or stopping) vector
                if (w_end) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRIVE;
                    w_vec_nxt   = r_vec + 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
                w_pass_nxt  = (r_err_mask == '0);
            end
        endcase
        w_busy_nxt = (w_state_nxt == DRIVE) || (w_state_nxt == SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_mask   <= '0;
            r_fail_cnt   <= 5'd0;
            r_first_fail <= 4'd0;
        end else begin
            r_vec        <= w_vec_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err_mask   <= w_err_mask_nxt;
            r_fail_cnt   <= w_fail_cnt_nxt;
            r_first_fail <= w_first_fail_nxt;
        end
    end

    assign vec        = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_mask   = r_err_mask;
    assign fail_cnt   = r_fail_cnt;
    assign first_fail = r_first_fail;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl with a modelled set of six implementations.
// Honours TT_SWEEP_STOP_ON_FAIL_EN when the build defines it.
module tb_tt_sweep_ctrl;

    localparam logic [15:0] G = 16'h7310;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] vec;
    logic [5:0] resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_mask;
    logic [4:0] fail_cnt;
    logic [3:0] first_fail;

    logic [5:0] stuck0;
    logic [5:0] stuck1;
    logic       g;

    int checks = 0;
    int errors = 0;
    int de;
    int nd;
    int k;
    bit hit;

    tt_sweep_ctrl #(
        .GOLDEN     (G),
        .N_IMPL     (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec        (vec),
        .resp       (resp),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_mask   (err_mask),
        .fail_cnt   (fail_cnt),
        .first_fail (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        g    = G[vec];
        resp = ({6{g}} & ~stuck0) | stuck1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start pulse sampled at edge 0; edges counted from there
    task automatic run_sweep(input int inj_vec, input int n_edges,
                             output int done_edge, output int n_done);
        bit injected;
        injected  = 1'b0;
        done_edge = -1;
        n_done    = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= n_edges; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = i;
            end
            if (inj_vec >= 0 && !injected && busy && vec == 4'(inj_vec)) begin
                start    = 1'b1;
                injected = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stuck0 = 6'b0;
        stuck1 = 6'b0;
        #1;
        chk("rst_vec",   32'(vec),        32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_pass",  32'(pass),       32'd0);
        chk("rst_err",   32'(err_mask),   32'd0);
        chk("rst_fcnt",  32'(fail_cnt),   32'd0);
        chk("rst_first", 32'(first_fail), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run_sweep(-1, 80, de, nd);
        chk("ok_done_edge", 32'(de),         32'd33);
        chk("ok_n_done",    32'(nd),         32'd1);
        chk("ok_pass",      32'(pass),       32'd1);
        chk("ok_err",       32'(err_mask),   32'd0);
        chk("ok_fcnt",      32'(fail_cnt),   32'd0);
        chk("ok_first",     32'(first_fail), 32'd0);
        chk("ok_vec_last",  32'(vec),        32'd15);
        chk("ok_busy_end",  32'(busy),       32'd0);

        stuck0 = 6'b000100;
        run_sweep(-1, 80, de, nd);
        chk("s0_done_edge", 32'(de),         32'd33);
        chk("s0_err",       32'(err_mask),   32'h04);
        chk("s0_fcnt",      32'(fail_cnt),   32'd6);
        chk("s0_first",     32'(first_fail), 32'd4);
        chk("s0_pass",      32'(pass),       32'd0);

        stuck0 = 6'b0;
        stuck1 = 6'b100000;
        run_sweep(-1, 80, de, nd);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        chk("s1_done_edge", 32'(de),         32'd3);
        chk("s1_fcnt",      32'(fail_cnt),   32'd1);
        chk("s1_vec_held",  32'(vec),        32'd0);
`else
        chk("s1_done_edge", 32'(de),         32'd33);
        chk("s1_fcnt",      32'(fail_cnt),   32'd10);
        chk("s1_vec_last",  32'(vec),        32'd15);
`endif
        chk("s1_n_done",    32'(nd),         32'd1);
        chk("s1_first",     32'(first_fail), 32'd0);
        chk("s1_err",       32'(err_mask),   32'h20);
        chk("s1_pass",      32'(pass),       32'd0);

        stuck1 = 6'b0;
        run_sweep(7, 80, de, nd);
        chk("inj_done_edge", 32'(de),         32'd33);
        chk("inj_n_done",    32'(nd),         32'd1);
        chk("inj_pass",      32'(pass),       32'd1);
        chk("inj_err",       32'(err_mask),   32'd0);
        chk("inj_fcnt",      32'(fail_cnt),   32'd0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        de = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done && de < 0) de = i;
            if (i == 34) begin
                chk("hold_busy34", 32'(busy), 32'd1);
                chk("hold_vec34",  32'(vec),  32'd0);
            end
        end
        chk("hold_done_edge", 32'(de), 32'd33);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (done) hit = 1'b1;
        end
        chk("hold_second_done", 32'(hit),  32'd1);
        chk("hold_second_pass", 32'(pass), 32'd1);

        stuck0 = 6'b000100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (busy && vec == 4'd9) hit = 1'b1;
        end
        chk("rs_reach_vec9", 32'(hit),      32'd1);
        chk("rs_pre_fcnt",   32'(fail_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rs_vec",   32'(vec),        32'd0);
        chk("rs_busy",  32'(busy),       32'd0);
        chk("rs_done",  32'(done),       32'd0);
        chk("rs_pass",  32'(pass),       32'd0);
        chk("rs_err",   32'(err_mask),   32'd0);
        chk("rs_fcnt",  32'(fail_cnt),   32'd0);
        chk("rs_first", 32'(first_fail), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        stuck0 = 6'b0;
        k = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
            if (busy) k++;
        end
        chk("rs_no_done", 32'(nd), 32'd0);
        chk("rs_no_busy", 32'(k),  32'd0);

        run_sweep(-1, 80, de, nd);
        chk("rs_new_done_edge", 32'(de),         32'd33);
        chk("rs_new_n_done",    32'(nd),         32'd1);
        chk("rs_new_pass",      32'(pass),       32'd1);
        chk("rs_new_fcnt",      32'(fail_cnt),   32'd0);
        chk("rs_new_err",       32'(err_mask),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
